// File: rtl/enc_64b.sv
// enc_64b: pipelined 64-to-6 priority encoder with zero and multi-hot flags.
// Stage 1 reduces each 8-bit group to {any, local index, multi}; stage 2
// picks the winning group and forms {group, local index}. Stage 2 is either
// registered (REG_OUT=1, latency 2) or combinational from stage 1 (latency 1).
//
// Handshake: a word moves across a port on any rising edge where that port's
// valid and ready are both high. A producer holds valid and data steady until
// the transfer. in_ready_o depends only on pipeline state and out_ready_i,
// never on in_valid_i. While out_valid_o && !out_ready_i the out_* values do
// not change.
module enc_64b #(
  parameter bit REG_OUT   = 1'b1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [5:0]  out_data_o,
  output logic        out_zero_o,
  output logic        out_multi_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  // Stage 1 state: one valid bit plus per-group summaries.
  logic       s1_valid_q;
  logic [7:0] s1_any_q, s1_any_d;
  logic [7:0] s1_multi_q, s1_multi_d;
  logic [2:0] s1_idx_q [8];
  logic [2:0] s1_idx_d [8];

  // Flow control between stages.
  logic s1_adv;
  logic s1_load;

  // Stage 2 combinational result computed from stage 1 registers.
  logic [2:0] win_g;
  logic [5:0] idx_c;
  logic       zero_c;
  logic       multi_c;

  assign in_ready_o = !s1_valid_q || s1_adv;
  assign s1_load    = in_valid_i && in_ready_o;

  // Per-group reduction of the incoming word: any bit, winning bit, multi-hot.
  always_comb begin
    logic [7:0] grp;
    for (int g = 0; g < 8; g++) begin
      grp           = in_data_i[8*g +: 8];
      s1_any_d[g]   = |grp;
      s1_multi_d[g] = (grp & (grp - 8'd1)) != 8'd0;
      s1_idx_d[g]   = 3'd0;
      if (MSB_FIRST) begin
        for (int b = 0; b < 8; b++)
          if (grp[b]) s1_idx_d[g] = 3'(b);
      end else begin
        for (int b = 7; b >= 0; b--)
          if (grp[b]) s1_idx_d[g] = 3'(b);
      end
    end
  end

  // Stage 1 valid: fill on input transfer, empty when content advances.
  always_ff @(posedge clk_i) begin
    if (rst_i)        s1_valid_q <= 1'b0;
    else if (s1_load) s1_valid_q <= 1'b1;
    else if (s1_adv)  s1_valid_q <= 1'b0;
  end

  // Stage 1 data: captured on every accepted word, no reset needed.
  always_ff @(posedge clk_i) begin
    if (s1_load) begin
      s1_any_q   <= s1_any_d;
      s1_multi_q <= s1_multi_d;
      for (int g = 0; g < 8; g++) s1_idx_q[g] <= s1_idx_d[g];
    end
  end

  // Winning group selection and final index/flag formation.
  always_comb begin
    win_g = 3'd0;
    if (MSB_FIRST) begin
      for (int g = 0; g < 8; g++)
        if (s1_any_q[g]) win_g = 3'(g);
    end else begin
      for (int g = 7; g >= 0; g--)
        if (s1_any_q[g]) win_g = 3'(g);
    end
    idx_c   = {win_g, s1_idx_q[win_g]};
    zero_c  = ~|s1_any_q;
    // More than one group active, or the winning group itself is multi-hot.
    multi_c = ((s1_any_q & (s1_any_q - 8'd1)) != 8'd0) || s1_multi_q[win_g];
  end

  if (REG_OUT) begin : g_reg_out
    logic       s2_valid_q;
    logic [5:0] s2_data_q;
    logic       s2_zero_q;
    logic       s2_multi_q;

    assign s1_adv = !s2_valid_q || out_ready_i;

    // Output register: load from stage 1 when it advances, drain on accept.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= 6'd0;
        s2_zero_q  <= 1'b0;
        s2_multi_q <= 1'b0;
      end else if (s1_valid_q && s1_adv) begin
        s2_valid_q <= 1'b1;
        s2_data_q  <= zero_c ? 6'd0 : idx_c;
        s2_zero_q  <= zero_c;
        s2_multi_q <= multi_c;
      end else if (out_ready_i) begin
        s2_valid_q <= 1'b0;
      end
    end

    assign out_valid_o = s2_valid_q;
    assign out_data_o  = s2_data_q;
    assign out_zero_o  = s2_zero_q;
    assign out_multi_o = s2_multi_q;
  end else begin : g_comb_out
    assign s1_adv = out_ready_i;

    // Outputs are forced to their idle values whenever stage 1 is empty.
    assign out_valid_o = s1_valid_q;
    assign out_data_o  = (s1_valid_q && !zero_c) ? idx_c : 6'd0;
    assign out_zero_o  = s1_valid_q && zero_c;
    assign out_multi_o = s1_valid_q && multi_c;
  end

endmodule

// File: tb/tb_enc_64b.sv
// Bench for enc_64b: instance A (REG_OUT=1, LSB priority) and instance B
// (REG_OUT=0, MSB priority). Expected responses come from a flat 64-bit
// reference model and are queued at input handshake, then popped and
// compared by per-instance monitors at output handshake.
module tb_enc_64b;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [63:0] a_in_data, b_in_data;
  logic        a_in_valid, b_in_valid;
  logic        a_in_ready, b_in_ready;
  logic [5:0]  a_out_data, b_out_data;
  logic        a_out_zero, b_out_zero;
  logic        a_out_multi, b_out_multi;
  logic        a_out_valid, b_out_valid;
  logic        a_out_ready, b_out_ready;

  enc_64b #(.REG_OUT(1'b1), .MSB_FIRST(1'b0)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_data_i(a_in_data), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .out_data_o(a_out_data), .out_zero_o(a_out_zero), .out_multi_o(a_out_multi),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready)
  );

  enc_64b #(.REG_OUT(1'b0), .MSB_FIRST(1'b1)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_data_i(b_in_data), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .out_data_o(b_out_data), .out_zero_o(b_out_zero), .out_multi_o(b_out_multi),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  int lat_a_q[$];
  int lat_b_q[$];
  int a_inflight = 0;
  bit a_lat_chk = 1'b0;
  bit a_post_rst = 1'b1;
  bit b_post_rst = 1'b1;
  bit bp_done, rnd_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at t=%0t", name, $time);
  endtask

  // Reference: packed {zero, multi, index} from the whole 64-bit word.
  function automatic logic [7:0] model(input logic [63:0] w, input bit msb);
    int idx = 0;
    int n   = $countones(w);
    if (msb) begin
      for (int i = 0; i < 64; i++) if (w[i]) idx = i;
    end else begin
      for (int i = 63; i >= 0; i--) if (w[i]) idx = i;
    end
    return {(w == 64'd0), (n > 1), 6'(idx)};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk_i) begin
    int lat;
    bit in_hs, out_hs;
    #2;
    if (rst_i) begin
      exp_a_q.delete();
      lat_a_q.delete();
      a_inflight = 0;
      a_post_rst = 1'b1;
    end else begin
      if (a_post_rst) begin
        check("a_valid_after_reset", {31'd0, a_out_valid}, 32'd0);
        a_post_rst = 1'b0;
      end
      check("a_in_ready", {31'd0, a_in_ready}, {31'd0, (a_out_ready || a_inflight < 2)});
      in_hs  = a_in_valid && a_in_ready;
      out_hs = a_out_valid && a_out_ready;
      if (a_out_valid) begin
        if (exp_a_q.size() == 0) fail_now("a_unexpected_output");
        else begin
          check("a_out", {24'd0, a_out_zero, a_out_multi, a_out_data}, {24'd0, exp_a_q[0]});
          if (a_out_ready) begin
            void'(exp_a_q.pop_front());
            lat = lat_a_q.pop_front();
            if (a_lat_chk) check("a_latency", cyc - lat, 32'd2);
          end
        end
      end
      if (in_hs) begin
        exp_a_q.push_back(model(a_in_data, 1'b0));
        lat_a_q.push_back(cyc);
      end
      a_inflight = a_inflight + int'(in_hs) - int'(out_hs);
    end
  end

  always @(negedge clk_i) begin
    int lat;
    #2;
    if (rst_i) begin
      exp_b_q.delete();
      lat_b_q.delete();
      b_post_rst = 1'b1;
    end else begin
      if (b_post_rst) begin
        check("b_valid_after_reset", {31'd0, b_out_valid}, 32'd0);
        b_post_rst = 1'b0;
      end
      check("b_in_ready", {31'd0, b_in_ready}, 32'd1);
      if (b_out_valid) begin
        if (exp_b_q.size() == 0) fail_now("b_unexpected_output");
        else begin
          check("b_out", {24'd0, b_out_zero, b_out_multi, b_out_data}, {24'd0, exp_b_q[0]});
          void'(exp_b_q.pop_front());
          lat = lat_b_q.pop_front();
          check("b_latency", cyc - lat, 32'd1);
        end
      end
      if (b_in_valid && b_in_ready) begin
        exp_b_q.push_back(model(b_in_data, 1'b1));
        lat_b_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic a_send(input logic [63:0] w);
    int t = 0;
    @(negedge clk_i);
    a_in_data  = w;
    a_in_valid = 1'b1;
    #1;
    while (!a_in_ready && t < 200) begin
      @(negedge clk_i);
      #1;
      t++;
    end
    if (t >= 200) fail_now("a_send_timeout");
  endtask

  task automatic a_idle();
    @(negedge clk_i);
    a_in_valid = 1'b0;
  endtask

  task automatic a_drain();
    int t = 0;
    while (exp_a_q.size() != 0 && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    if (exp_a_q.size() != 0) fail_now("a_drain_timeout");
    @(negedge clk_i);
  endtask

  task automatic b_send(input logic [63:0] w);
    int t = 0;
    @(negedge clk_i);
    b_in_data  = w;
    b_in_valid = 1'b1;
    #1;
    while (!b_in_ready && t < 200) begin
      @(negedge clk_i);
      #1;
      t++;
    end
    if (t >= 200) fail_now("b_send_timeout");
  endtask

  task automatic b_idle();
    @(negedge clk_i);
    b_in_valid = 1'b0;
  endtask

  task automatic b_drain();
    int t = 0;
    while (exp_b_q.size() != 0 && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    if (exp_b_q.size() != 0) fail_now("b_drain_timeout");
    @(negedge clk_i);
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    case ($urandom_range(0, 3))
      0:       w = 64'd1 << $urandom_range(0, 63);
      1:       w = 64'd0;
      2:       w = {$urandom(), $urandom()};
      default: w = (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 63));
    endcase
    return w;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    a_in_valid = 1'b0; a_in_data = 64'd0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 64'd0; b_out_ready = 1'b1;
    bp_done = 1'b0; rnd_done = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #3;
    check("a_rst_valid", {31'd0, a_out_valid}, 32'd0);
    check("a_rst_data",  {26'd0, a_out_data}, 32'd0);
    check("a_rst_zero",  {31'd0, a_out_zero}, 32'd0);
    check("a_rst_multi", {31'd0, a_out_multi}, 32'd0);
    check("a_rst_ready", {31'd0, a_in_ready}, 32'd1);
    check("b_rst_valid", {31'd0, b_out_valid}, 32'd0);
    check("b_rst_data",  {26'd0, b_out_data}, 32'd0);
    check("b_rst_zero",  {31'd0, b_out_zero}, 32'd0);
    check("b_rst_multi", {31'd0, b_out_multi}, 32'd0);
    check("b_rst_ready", {31'd0, b_in_ready}, 32'd1);

    // One-hot sweep, back-to-back, latency 2.
    a_lat_chk = 1'b1;
    for (int i = 0; i < 64; i++) a_send(64'd1 << i);
    a_idle();
    a_drain();

    // Zero, multi-hot and group-boundary words.
    a_send(64'd0);
    a_send(64'h8000_0000_0000_0101);
    a_send(64'h0000_0000_0000_0180);
    a_send(64'h0180_0000_0000_0000);
    a_send(64'h8000_0000_0000_0000);
    a_send(64'hFFFF_FFFF_FFFF_FFFF);
    a_idle();
    a_drain();
    a_lat_chk = 1'b0;

    // Backpressure: ten words with out_ready pattern 1,0,0 repeating.
    fork
      begin
        for (int k = 0; k < 10; k++) a_send(64'd1 << $urandom_range(0, 63));
        a_idle();
        bp_done = 1'b1;
      end
      begin
        int p = 0;
        while (!bp_done) begin
          @(negedge clk_i);
          a_out_ready = (p % 3 == 0);
          p++;
        end
      end
    join
    a_out_ready = 1'b0;
    repeat (4) @(negedge clk_i);
    a_out_ready = 1'b1;
    a_drain();

    // Fill the pipe with out_ready low; a third word must be refused.
    @(negedge clk_i);
    a_out_ready = 1'b0;
    a_send(64'h0000_0000_0000_0080);
    a_send(64'h0000_0000_0000_0100);
    @(negedge clk_i);
    a_in_data = 64'h0100_0000_0000_0000;
    a_in_valid = 1'b1;
    #1;
    check("a_full_in_ready", {31'd0, a_in_ready}, 32'd0);
    repeat (2) @(negedge clk_i);
    a_out_ready = 1'b1;
    a_idle();
    a_drain();

    // Random words with random downstream backpressure.
    fork
      begin
        for (int k = 0; k < 300; k++) a_send(rand_word());
        a_idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk_i);
          a_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    a_out_ready = 1'b1;
    a_drain();

    // Round trip: decoded index k re-encodes to k.
    a_lat_chk = 1'b1;
    for (int k = 0; k < 1000; k++) a_send(64'd1 << $urandom_range(0, 63));
    a_idle();
    a_drain();
    a_lat_chk = 1'b0;

    // Reset with two words in flight, then a fresh word.
    a_send(64'h0000_0000_0001_0000);
    a_send(64'h0000_0010_0000_0000);
    @(negedge clk_i);
    a_in_valid = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    a_send(64'h0000_0000_0000_0400);
    a_idle();
    a_drain();

    // Instance B: combinational output stage, MSB priority, latency 1.
    for (int i = 0; i < 64; i++) b_send(64'd1 << i);
    b_send(64'd0);
    b_send(64'h8000_0000_0000_0101);
    b_send(64'h0000_0000_0000_0180);
    b_send(64'h0180_0000_0000_0000);
    for (int k = 0; k < 150; k++) b_send(rand_word());
    b_idle();
    b_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
